// File: rtl/tdc_spi_config.sv
// SPI configuration sequencer for a TDC: writes CONFIG2, INT_MASK and CONFIG1 in SPI mode 0.
// Optional macro TDC_READBACK_EN adds a CONFIG2 read-back frame and verifies the returned byte.
module tdc_spi_config #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [7:0]  CFG1_VAL = 8'h00,
    parameter logic [7:0]  CFG2_VAL = 8'h40,
    parameter logic [7:0]  INTM_VAL = 8'h07
) (
    input  logic clk,
    input  logic rst,
    input  logic tdc_enable,
    input  logic soft_reset,
    output logic sclk,
    output logic csn,
    output logic mosi,
    input  logic miso,
    output logic busy,
    output logic cfg_done,
    output logic cfg_err
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
`ifdef TDC_READBACK_EN
    localparam logic [1:0] LAST_FRAME = 2'd3;
`else
    localparam logic [1:0] LAST_FRAME = 2'd2;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, FINISH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic        half_q, half_d;
    logic [1:0]  frame_q, frame_d;
    logic        err_d, done_d, busy_d, csn_d, sclk_d, mosi_d;
    logic [15:0] word_d;
    logic        div_end;
`ifdef TDC_READBACK_EN
    logic [7:0]  rx_q, rx_d;
`else
    logic        unused_miso;
    assign unused_miso = miso;
`endif

    function automatic logic [15:0] frame_word(input logic [1:0] idx);
        case (idx)
            2'd0:    frame_word = {8'h41, CFG2_VAL};
            2'd1:    frame_word = {8'h43, INTM_VAL};
            2'd2:    frame_word = {8'h40, CFG1_VAL};
            default: frame_word = {8'h01, 8'h00};
        endcase
    endfunction

    // Next-state, counters and next values of the registered SPI outputs
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        half_d  = half_q;
        frame_d = frame_q;
        err_d   = cfg_err;
`ifdef TDC_READBACK_EN
        rx_d    = rx_q;
`endif
        div_end = (div_q == DIV_LAST);

        case (state_q)
            IDLE: begin
                div_d   = 8'd0;
                bit_d   = 4'd0;
                half_d  = 1'b0;
                frame_d = 2'd0;
                if (soft_reset && tdc_enable) begin
                    state_d = SETUP;
                    err_d   = 1'b0;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_d   = 8'd0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_d = 8'd0;
                    if (!half_q) begin
                        half_d = 1'b1;
`ifdef TDC_READBACK_EN
                        rx_d   = {rx_q[6:0], miso};
`endif
                    end else begin
                        half_d = 1'b0;
                        if (bit_q == 4'd15) state_d = HOLD;
                        else                bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    div_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                // Two divider passes give the 2*CLK_DIV inter-frame gap without widening the divider
                if (div_end) begin
                    div_d = 8'd0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        bit_d  = 4'd0;
                        if (frame_q == LAST_FRAME) begin
                            state_d = FINISH;
`ifdef TDC_READBACK_EN
                            if (rx_q != CFG2_VAL) err_d = 1'b1;
`endif
                        end else begin
                            frame_d = frame_q + 2'd1;
                            state_d = SETUP;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q inside {SETUP, SHIFT, HOLD, GAP}) && !tdc_enable) begin
            state_d = FINISH;
            err_d   = 1'b1;
        end

        word_d = frame_word(frame_d);
        done_d = (state_d == FINISH);
        busy_d = (state_d inside {SETUP, SHIFT, HOLD, GAP});
        csn_d  = !(state_d inside {SETUP, SHIFT, HOLD});
        sclk_d = (state_d == SHIFT) && half_d;
        mosi_d = (state_d inside {SETUP, SHIFT}) ? word_d[~bit_d] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= 8'd0;
            bit_q    <= 4'd0;
            half_q   <= 1'b0;
            frame_q  <= 2'd0;
            sclk     <= 1'b0;
            csn      <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
`ifdef TDC_READBACK_EN
            rx_q     <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            half_q   <= half_d;
            frame_q  <= frame_d;
            sclk     <= sclk_d;
            csn      <= csn_d;
            mosi     <= mosi_d;
            busy     <= busy_d;
            cfg_done <= done_d;
            cfg_err  <= err_d;
`ifdef TDC_READBACK_EN
            rx_q     <= rx_d;
`endif
        end
    end

endmodule

// File: tb/tb_tdc_spi_config.sv
// Directed bench for tdc_spi_config: frame contents, csn timing, abort, ignored requests, reset.
module tb_tdc_spi_config;

`ifdef TDC_READBACK_EN
    localparam int NF = 4;
`else
    localparam int NF = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tdc_enable = 1'b0;
    logic soft_reset = 1'b0;
    logic miso = 1'b0;
    logic sclk, csn, mosi, busy, cfg_done, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_w [4] = '{16'h4140, 16'h4307, 16'h4000, 16'h0100};

    logic [7:0]  rb_val = 8'h40;
    logic [15:0] miso_sr = 16'h0;

    logic [15:0] mon_word [64];
    int          mon_low  [64];
    int          mon_bits [64];
    int          mon_nf = 0;
    int          cur_low = 0, cur_bits = 0, done_cnt = 0, sclk_rises = 0;
    logic [15:0] cur_word = 16'h0;
    logic        prev_sclk = 1'b0, prev_csn = 1'b1;

    tdc_spi_config #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .tdc_enable(tdc_enable), .soft_reset(soft_reset),
        .sclk(sclk), .csn(csn), .mosi(mosi), .miso(miso),
        .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Bus monitor plus TDC model (miso changes on sclk falling edge, loaded at csn fall)
    always @(negedge clk) begin
        if (rst) begin
            cur_low = 0; cur_bits = 0; cur_word = 16'h0;
            prev_sclk = 1'b0; prev_csn = 1'b1;
        end else begin
            if (!csn && prev_csn) begin
                miso_sr = {8'h00, rb_val};
                miso = miso_sr[15];
            end else if (!sclk && prev_sclk && !csn) begin
                miso_sr = {miso_sr[14:0], 1'b0};
                miso = miso_sr[15];
            end
            if (!csn) cur_low++;
            if (sclk && !prev_sclk) begin
                sclk_rises++;
                if (!csn) begin
                    cur_word = {cur_word[14:0], mosi};
                    cur_bits++;
                end
            end
            if (csn && !prev_csn) begin
                if (mon_nf < 64) begin
                    mon_word[mon_nf] = cur_word;
                    mon_low[mon_nf]  = cur_low;
                    mon_bits[mon_nf] = cur_bits;
                end
                mon_nf++;
                cur_low = 0; cur_bits = 0; cur_word = 16'h0;
            end
            if (cfg_done) done_cnt++;
            prev_sclk = sclk;
            prev_csn  = csn;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_soft_reset();
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (cfg_done !== 1'b1 && k < 2000) begin
            step(1);
            k++;
        end
        n_checks++;
        if (cfg_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: cfg_done=%b expected 1 within 2000 cycles", name, cfg_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_checks += 6;
        if (csn !== 1'b1)      begin n_fail++; $display("FAIL reset_csn: got %b expected 1", csn); end
        if (sclk !== 1'b0)     begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        if (mosi !== 1'b0)     begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", cfg_done); end
        if (cfg_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
        rst = 1'b0;
        tdc_enable = 1'b1;
        step(2);
    endtask

    task automatic check_frames(input string name, input int base, input int base_done);
        n_checks += 2;
        if (mon_nf - base != NF) begin
            n_fail++; $display("FAIL %s_nframes: got %0d expected %0d", name, mon_nf - base, NF);
        end
        if (done_cnt - base_done != 1) begin
            n_fail++; $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt - base_done);
        end
        for (int i = 0; i < NF; i++) begin
            n_checks += 3;
            if (mon_word[base+i] !== exp_w[i]) begin
                n_fail++; $display("FAIL %s_word%0d: got %h expected %h", name, i, mon_word[base+i], exp_w[i]);
            end
            if (mon_low[base+i] != 136) begin
                n_fail++; $display("FAIL %s_csn_low%0d: got %0d expected 136", name, i, mon_low[base+i]);
            end
            if (mon_bits[base+i] != 16) begin
                n_fail++; $display("FAIL %s_bits%0d: got %0d expected 16", name, i, mon_bits[base+i]);
            end
        end
    endtask

    task automatic run_sequence(input string name, input logic exp_err);
        int base, base_done;
        base = mon_nf;
        base_done = done_cnt;
        pulse_soft_reset();
        n_checks += 3;
        if (busy !== 1'b1)    begin n_fail++; $display("FAIL %s_busy_start: got %b expected 1", name, busy); end
        if (csn !== 1'b0)     begin n_fail++; $display("FAIL %s_csn_start: got %b expected 0", name, csn); end
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL %s_err_start: got %b expected 0", name, cfg_err); end
        wait_done(name);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_at_done: got %b expected 0", name, busy); end
        step(3);
        n_checks += 2;
        if (cfg_err !== exp_err) begin n_fail++; $display("FAIL %s_err: got %b expected %b", name, cfg_err, exp_err); end
        if (cfg_done !== 1'b0)   begin n_fail++; $display("FAIL %s_done_width: got %b expected 0", name, cfg_done); end
        check_frames(name, base, base_done);
    endtask

    task automatic test_config();
        rb_val = 8'h40;
        run_sequence("config", 1'b0);
    endtask

`ifdef TDC_READBACK_EN
    task automatic test_readback_mismatch();
        rb_val = 8'h41;
        run_sequence("rb_bad", 1'b1);
        rb_val = 8'h40;
    endtask
`endif

    task automatic test_abort();
        int base, base_done, k;
        base = mon_nf;
        base_done = done_cnt;
        pulse_soft_reset();
        k = 0;
        while (!(mon_nf == base + 1 && cur_bits == 5) && k < 2000) begin
            step(1);
            k++;
        end
        n_checks++;
        if (k >= 2000) begin n_fail++; $display("FAIL abort_reach_bit: frame %0d bit %0d not reached", base + 1, 5); end
        tdc_enable = 1'b0;
        step(1);
        n_checks += 4;
        if (csn !== 1'b1)      begin n_fail++; $display("FAIL abort_csn: got %b expected 1", csn); end
        if (sclk !== 1'b0)     begin n_fail++; $display("FAIL abort_sclk: got %b expected 0", sclk); end
        if (mosi !== 1'b0)     begin n_fail++; $display("FAIL abort_mosi: got %b expected 0", mosi); end
        if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b expected 1", cfg_done); end
        step(3);
        n_checks += 3;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL abort_err: got %b expected 1", cfg_err); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (done_cnt - base_done != 1) begin
            n_fail++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt - base_done);
        end
        tdc_enable = 1'b1;
        step(2);
    endtask

    task automatic test_ignored_requests();
        int base, base_done;
        // request while disabled, and a coincident enable fall, must not start
        tdc_enable = 1'b0;
        pulse_soft_reset();
        step(3);
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL disabled_busy: got %b expected 0", busy); end
        if (csn !== 1'b1)  begin n_fail++; $display("FAIL disabled_csn: got %b expected 1", csn); end
        tdc_enable = 1'b1;
        step(2);
        tdc_enable = 1'b0;
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        step(3);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL coincide_busy: got %b expected 0", busy); end
        tdc_enable = 1'b1;
        step(2);
        // second request while busy is ignored
        base = mon_nf;
        base_done = done_cnt;
        pulse_soft_reset();
        step(49);
        pulse_soft_reset();
        wait_done("busy_req");
        step(3);
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL busy_req_err: got %b expected 0", cfg_err); end
        check_frames("busy_req", base, base_done);
        step(300);
        n_checks++;
        if (mon_nf - base != NF) begin
            n_fail++; $display("FAIL busy_req_restart: got %0d frames expected %0d", mon_nf - base, NF);
        end
    endtask

    task automatic test_reset_mid_frame();
        int snap;
        pulse_soft_reset();
        step(30);
        rst = 1'b1;
        step(1);
        n_checks += 4;
        if (csn !== 1'b1)  begin n_fail++; $display("FAIL midrst_csn: got %b expected 1", csn); end
        if (sclk !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk: got %b expected 0", sclk); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (mosi !== 1'b0) begin n_fail++; $display("FAIL midrst_mosi: got %b expected 0", mosi); end
        rst = 1'b0;
        snap = sclk_rises;
        step(300);
        n_checks += 2;
        if (sclk_rises != snap) begin
            n_fail++; $display("FAIL midrst_sclk_edges: got %0d expected 0", sclk_rises - snap);
        end
        if (csn !== 1'b1) begin n_fail++; $display("FAIL midrst_csn_idle: got %b expected 1", csn); end
    endtask

    initial begin
        test_reset();
        test_config();
`ifdef TDC_READBACK_EN
        test_readback_mismatch();
`endif
        test_abort();
        test_ignored_requests();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_spi_config.md
TDC_SPI_CONFIG -- requirements
Module: tdc_spi_config

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period, legal range 2..255.
REQ-002 The block SHALL have parameter CFG1_VAL, default 8'h00: CONFIG1 register data.
REQ-003 The block SHALL have parameter CFG2_VAL, default 8'h40: CONFIG2 register data.
REQ-004 The block SHALL have parameter INTM_VAL, default 8'h07: INT_MASK register data.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port tdc_enable, input, 1 bit: TDC enable level from the main controller.
REQ-008 The block SHALL have port soft_reset, input, 1 bit: one-cycle request pulse to (re)configure the TDC.
REQ-009 The block SHALL have port sclk, output, 1 bit: SPI clock.
REQ-010 The block SHALL have port csn, output, 1 bit: SPI chip select, active-low.
REQ-011 The block SHALL have port mosi, output, 1 bit: SPI data to the TDC.
REQ-012 The block SHALL have port miso, input, 1 bit: SPI data from the TDC.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-014 The block SHALL have port cfg_done, output, 1 bit: one-cycle pulse when a sequence ends, whether pass or fail.
REQ-015 The block SHALL have port cfg_err, output, 1 bit: sticky error flag, cleared at the next sequence start.

Function
REQ-016 The block SHALL start a sequence in the cycle after soft_reset=1 while tdc_enable=1 and busy=0; a soft_reset pulse while busy=1 or while tdc_enable=0 SHALL be ignored.
REQ-017 On sequence start the block SHALL set busy=1 and cfg_err=0.
REQ-018 The block SHALL send frames in the order: write CONFIG2 (address 0x01), write INT_MASK (address 0x03), write CONFIG1 (address 0x00).
REQ-019 Each frame SHALL be 16 bits, MSB first: command byte (bit7=0, bit6=1 for write / 0 for read, bits5:0=address) followed by the data byte.
REQ-020 Frames SHALL use SPI mode 0: sclk idle low, mosi updated on the sclk falling edge (or at csn fall for bit15), miso sampled on the sclk rising edge.
REQ-021 Frame timing SHALL be: csn low, CLK_DIV cycles setup, 16 sclk periods of 2*CLK_DIV cycles (low half first), CLK_DIV cycles hold, then csn high for at least 2*CLK_DIV cycles before the next frame.
REQ-022 With CLK_DIV=4, csn SHALL stay low for exactly 136 cycles per frame.
REQ-023 States SHALL be: IDLE -> SETUP -> SHIFT -> HOLD -> GAP, then the next frame's SETUP, or FINISH after the last frame; FINISH -> IDLE.
REQ-024 In FINISH the block SHALL assert cfg_done for exactly one cycle; busy SHALL fall in that same cycle.
REQ-025 If tdc_enable falls at any point during a sequence, the block SHALL abort within 1 cycle: csn=1, sclk=0, mosi=0, cfg_err=1, a one-cycle cfg_done pulse, then return to IDLE.
REQ-026 The bit counter SHALL be 4 bits wide and SHALL NOT wrap within a frame; the divider counter SHALL be 8 bits wide.
REQ-027 If soft_reset and a tdc_enable fall coincide in IDLE, the block SHALL NOT start a sequence.

Reset
REQ-028 While rst=1 the block SHALL force state=IDLE, sclk=0, csn=1, mosi=0, busy=0, cfg_done=0, cfg_err=0, and clear all counters.
REQ-029 A reset asserted mid-frame SHALL take effect on the next clk edge, and no partial frame SHALL resume after reset.

Configuration
REQ-030 When macro TDC_READBACK_EN is defined, the block SHALL append a fourth frame, read CONFIG2 (command 0x01, data bits 0x00), capture the miso data byte, and set cfg_err=1 if the captured byte differs from CFG2_VAL.
REQ-031 When TDC_READBACK_EN is undefined, the block SHALL send only three frames, SHALL ignore miso, and SHALL set cfg_err only on abort.

Verification
REQ-032 The bench SHALL cover: tdc_enable=1 and a soft_reset pulse, CLK_DIV=4, no readback -> mosi frames 0x4140, 0x4307, 0x4000, each with csn low 136 cycles; cfg_done pulses once; cfg_err=0.
REQ-033 The bench SHALL cover: TDC_READBACK_EN defined with the TDC model returning 0x40 -> a fourth frame with command 0x01 is sent; cfg_err=0.
REQ-034 The bench SHALL cover: TDC_READBACK_EN defined with the model returning 0x41 -> cfg_err=1 after cfg_done.
REQ-035 The bench SHALL cover: tdc_enable dropped during frame 2, bit 5 -> csn=1 within 1 cycle, then cfg_done and cfg_err=1.
REQ-036 The bench SHALL cover: a second soft_reset 50 cycles after start -> ignored; still exactly 3 frames and 1 cfg_done.
REQ-037 The bench SHALL cover: rst=1 for 1 cycle mid-frame -> next cycle csn=1, sclk=0, busy=0; no further sclk edges without a new soft_reset.
